// File: rtl/mips_tag_pkg.sv
// mips_tag_pkg
// Shared definitions for the tag allocation path of the out-of-order MIPS core.
//   TAG_WIDTH / NUM_TAGS : tag width in bits and number of tags (= tag FIFO depth)
//   CNT_WIDTH            : width of a free-tag count (must hold 0..NUM_TAGS)
//   tag_t                : one physical tag
//   tag_state_e          : allocation controller FSM states
package mips_tag_pkg;

  localparam int TAG_WIDTH = 5;
  localparam int NUM_TAGS  = 32;
  localparam int CNT_WIDTH = 6;

  typedef logic [TAG_WIDTH-1:0] tag_t;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } tag_state_e;

endpackage

// File: rtl/tag_outstanding_map.sv
// tag_outstanding_map
// One bit per tag, set while the tag is held by the pipeline (granted and not
// yet returned). Lookup is purely combinational off the registered map.
// Ports:
//   clock, reset            : clock, synchronous active-high reset (clears map)
//   set_en_i, set_tag_i     : mark a tag outstanding
//   clr_en_i, clr_tag_i     : mark a tag returned
//   lookup_tag_i            : tag to query
//   is_outstanding_o        : map bit for lookup_tag_i
module tag_outstanding_map #(
  parameter int TAG_WIDTH = 5,
  parameter int NUM_TAGS  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en_i,
  input  logic [TAG_WIDTH-1:0] set_tag_i,
  input  logic                 clr_en_i,
  input  logic [TAG_WIDTH-1:0] clr_tag_i,
  input  logic [TAG_WIDTH-1:0] lookup_tag_i,
  output logic                 is_outstanding_o
);

  logic [NUM_TAGS-1:0] map_q;

  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_bit
    always_ff @(posedge clock) begin
      if (reset) begin
        map_q[gi] <= 1'b0;
      end else if (set_en_i && (set_tag_i == TAG_WIDTH'(gi))) begin
        map_q[gi] <= 1'b1;
      end else if (clr_en_i && (clr_tag_i == TAG_WIDTH'(gi))) begin
        map_q[gi] <= 1'b0;
      end
    end
  end

  assign is_outstanding_o = map_q[lookup_tag_i];

endmodule

// File: rtl/tag_alloc_ctrl.sv
// tag_alloc_ctrl
// Sequences the external 32-entry tag FIFO: seeds it with tags 0..NUM_TAGS-1
// after reset, grants tags to dispatch, arbitrates the single FIFO write port
// between the retire bus (fixed priority) and the squash return path, and
// rejects returns that would corrupt the free list (duplicates, overflow).
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   disp_req, disp_has_rd            : dispatch request / needs a destination tag
//   disp_grant, disp_stall           : combinational dispatch handshake
//   disp_tag_valid, disp_tag         : allocated tag, one cycle after the FIFO read
//   rb_tag_valid, rb_tag             : retire-bus tag return (no backpressure)
//   sq_valid, sq_tag, sq_ready       : squash tag return with ready
//   fifo_rd_en, fifo_wr_en, fifo_wr_tag, fifo_tag_out : tag FIFO interface
//   free_cnt                         : tags currently held in the FIFO
//   err_overflow, err_dup            : sticky error flags, cleared by reset
module tag_alloc_ctrl #(
  parameter int TAG_WIDTH = 5,
  parameter int NUM_TAGS  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 disp_req,
  input  logic                 disp_has_rd,
  output logic                 disp_grant,
  output logic                 disp_stall,
  output logic                 disp_tag_valid,
  output logic [TAG_WIDTH-1:0] disp_tag,
  input  logic [TAG_WIDTH-1:0] rb_tag,
  input  logic                 rb_tag_valid,
  input  logic [TAG_WIDTH-1:0] sq_tag,
  input  logic                 sq_valid,
  output logic                 sq_ready,
  output logic                 fifo_rd_en,
  output logic                 fifo_wr_en,
  output logic [TAG_WIDTH-1:0] fifo_wr_tag,
  input  logic [TAG_WIDTH-1:0] fifo_tag_out,
  output logic [5:0]           free_cnt,
  output logic                 err_overflow,
  output logic                 err_dup
);

  import mips_tag_pkg::*;

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_TAGS);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(NUM_TAGS - 1);

  tag_state_e           state_q;
  logic [TAG_WIDTH-1:0] init_cnt_q;
  logic [CNT_WIDTH-1:0] free_cnt_q;
  logic                 disp_tag_valid_q;
  logic                 err_dup_q;
  logic                 err_overflow_q;

  logic                 in_run;
  logic                 cnt_empty;
  logic                 cnt_full;
  logic                 rd_ok;
  logic                 ret_valid;
  logic [TAG_WIDTH-1:0] ret_tag;
  logic                 ret_outstanding;
  logic                 ret_ok;
  logic                 wr_fire;
  logic                 rd_fire;

  assign in_run    = (state_q == S_RUN);
  assign cnt_empty = (free_cnt_q == '0);
  assign cnt_full  = (free_cnt_q == FULL_CNT);

  // Dispatch: only instructions with a destination consume a tag.
  assign rd_ok      = in_run && disp_req && disp_has_rd && !cnt_empty;
  assign disp_grant = in_run && disp_req && (!disp_has_rd || !cnt_empty);
  assign disp_stall = disp_req && (!in_run || (disp_has_rd && cnt_empty));

  // Return arbitration: the retire bus always wins; squash waits for a free slot.
  assign sq_ready  = in_run && !rb_tag_valid;
  assign ret_valid = in_run && (rb_tag_valid || sq_valid);
  assign ret_tag   = rb_tag_valid ? rb_tag : sq_tag;
  assign ret_ok    = ret_valid && ret_outstanding && !cnt_full;

  // FIFO strobes are held low during reset so the FIFO sees no stray access
  // while it is being reset alongside this block.
  assign wr_fire     = !reset && (!in_run || ret_ok);
  assign rd_fire     = !reset && rd_ok;
  assign fifo_wr_en  = wr_fire;
  assign fifo_rd_en  = rd_fire;
  assign fifo_wr_tag = in_run ? ret_tag : init_cnt_q;

  // The FIFO output is already registered, so the tag is forwarded directly.
  assign disp_tag_valid = disp_tag_valid_q;
  assign disp_tag       = disp_tag_valid_q ? fifo_tag_out : '0;
  assign free_cnt       = free_cnt_q;
  assign err_dup        = err_dup_q;
  assign err_overflow   = err_overflow_q;

  tag_outstanding_map #(
    .TAG_WIDTH (TAG_WIDTH),
    .NUM_TAGS  (NUM_TAGS)
  ) u_map (
    .clock            (clock),
    .reset            (reset),
    .set_en_i         (disp_tag_valid_q),
    .set_tag_i        (fifo_tag_out),
    .clr_en_i         (ret_ok),
    .clr_tag_i        (ret_tag),
    .lookup_tag_i     (ret_tag),
    .is_outstanding_o (ret_outstanding)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_INIT;
      init_cnt_q       <= '0;
      free_cnt_q       <= '0;
      disp_tag_valid_q <= 1'b0;
      err_dup_q        <= 1'b0;
      err_overflow_q   <= 1'b0;
    end else begin
      disp_tag_valid_q <= rd_fire;

      // Simultaneous read and write cancel out.
      if (wr_fire && !rd_fire) begin
        free_cnt_q <= free_cnt_q + 1'b1;
      end else if (rd_fire && !wr_fire) begin
        free_cnt_q <= free_cnt_q - 1'b1;
      end

      unique case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_TAG) begin
            state_q <= S_RUN;
          end
          // Nothing can be outstanding yet, so any retire is a duplicate.
          if (rb_tag_valid) begin
            err_dup_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (ret_valid && !ret_outstanding) begin
            err_dup_q <= 1'b1;
          end
          if (ret_valid && cnt_full) begin
            err_overflow_q <= 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/tag_alloc_ctrl.md
# tag_alloc_ctrl

Controller that sequences the 32-entry tag FIFO (`tagfifo`) for the out-of-order MIPS core. After reset, it fills the FIFO with tags 0..31. It then grants tags to the dispatch unit. It arbitrates the single FIFO write port between the retire bus and the squash-return path. It also tracks outstanding tags so that duplicate returns and overflow are caught before they corrupt the free list.

## Interface
- `TAG_WIDTH`, 5, tag width in bits
- `NUM_TAGS`, 32, number of tags and FIFO depth
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `disp_req`  in  1  dispatch unit presents an instruction this cycle
- `disp_has_rd`  in  1  the instruction has a destination register
- `disp_grant`  out  1  the instruction may dispatch this cycle (combinational)
- `disp_stall`  out  1  dispatch must hold (combinational)
- `disp_tag_valid`  out  1  `disp_tag` is valid; asserted the cycle after a tag read
- `disp_tag`  out  TAG_WIDTH  allocated tag
- `rb_tag`, `rb_tag_valid`  in  TAG_WIDTH, 1  retire-bus tag return
- `sq_tag`, `sq_valid`  in  TAG_WIDTH, 1  squash-path tag return
- `sq_ready`  out  1  squash return accepted this cycle
- `fifo_rd_en`  out  1  to tagfifo `Rd_en`
- `fifo_wr_en`, `fifo_wr_tag`  out  1, TAG_WIDTH  to tagfifo `RB_Tag_Valid` and `RB_Tag`
- `fifo_tag_out`  in  TAG_WIDTH  from tagfifo `Tag_Out` (registered)
- `free_cnt`  out  6  free tags held in the FIFO (0..32)
- `err_overflow`, `err_dup`  out  1 each  sticky error flags; cleared only by reset

## Operation
- FSM has two states, `S_INIT` and `S_RUN`. Reset forces `S_INIT` with `init_cnt`=0.
- **`S_INIT`:**
  - `fifo_wr_en`=1 and `fifo_wr_tag`=`init_cnt` for 32 consecutive cycles.
  - After writing tag 31, the FSM moves to `S_RUN` with `free_cnt`=32.
  - While in `S_INIT`: `disp_grant`=0, `disp_stall`=`disp_req`, and `sq_ready`=0.
  - An `rb_tag_valid` in `S_INIT` sets `err_dup` and is dropped.
- **Dispatch in `S_RUN`:**
  - If `disp_req` and not `disp_has_rd`: `disp_grant`=1 and no FIFO read.
  - If `disp_req` and `disp_has_rd` and `free_cnt`≠0: `disp_grant`=1 and `fifo_rd_en`=1.
  - If `disp_req` and `disp_has_rd` and `free_cnt`=0: `disp_stall`=1.
  - `fifo_rd_en` is never asserted when `free_cnt`=0. The FIFO updates `Tag_Out` on any `Rd_en`, so this guard is mandatory.
- **Return arbitration:**
  - The retire bus has fixed priority and no backpressure.
  - `sq_ready` = `S_RUN` and not `rb_tag_valid`.
  - The selected tag is driven on `fifo_wr_tag` with `fifo_wr_en`=1 only if the tag's outstanding bit is set and `free_cnt`<32.
- **Outstanding map:** a `NUM_TAGS`-bit vector, all zeros at reset.
  - A bit is set on the `disp_tag_valid` cycle for `disp_tag`.
  - A bit is cleared on an accepted return.
  - A return whose bit is clear sets `err_dup` and the write is suppressed.
  - A return when `free_cnt`=32 sets `err_overflow` and the write is suppressed.
- **`free_cnt` update:** +1 per write, −1 per read; a read and a write in the same cycle leave it unchanged. Read eligibility uses the registered `free_cnt`; there is no same-cycle bypass from a return.

## Timing
- **Reset values:** `disp_tag_valid`=0, `disp_tag`=0, `free_cnt`=0, `err_*`=0, `fifo_wr_en`=0, `fifo_rd_en`=0.
- The first grant with a destination is possible 33 cycles after reset deasserts (32 init writes, then `S_RUN`).
- **Tag latency:**
  - `fifo_rd_en` is asserted in cycle N.
  - `fifo_tag_out` is valid in N+1.
  - `disp_tag_valid`=1 and `disp_tag`=`fifo_tag_out` in N+1, for one cycle.
- Back-to-back grants are allowed every cycle while `free_cnt`≠0.
- A returned tag is visible in `free_cnt` the cycle after the write. It can be re-read no earlier than that cycle.
- If reset asserts mid-`S_INIT` or mid-`S_RUN`, the block restarts `S_INIT` from 0. A pending `disp_tag_valid` is dropped. The external tagfifo must be reset in the same cycle.

## Structure
- Shared package `mips_tag_pkg` holds:
  - `TAG_WIDTH`, `NUM_TAGS`, `CNT_WIDTH`=6.
  - The `tag_t` typedef.
  - The FSM state enum `{S_INIT, S_RUN}`.
- One sub-module, `tag_outstanding_map`: the bitmap with set and clear ports and a combinational `is_outstanding(tag)` lookup.
- tagfifo is instantiated alongside at the next level up, not inside this block.

## Test plan
- **Init:** release reset and hold `disp_req`=0 → `fifo_wr_tag` runs 0..31 over 32 cycles; `free_cnt`=32 in cycle 33.
- **Grant latency:** `disp_req`=`disp_has_rd`=1 for 3 cycles starting in cycle 33 → `fifo_rd_en` high for 3 cycles; `disp_tag`=0, 1, 2 with `disp_tag_valid` one cycle later; `free_cnt`=29.
- **Exhaustion:** 32 grants, then request a 33rd → `disp_stall`=1 and `fifo_rd_en`=0. Then retire tag 7 → the next cycle grants and `disp_tag`=7.
- **Arbitration:** `rb_tag`=3 and `sq_tag`=4 both valid in the same cycle → tag 3 is written and `sq_ready`=0; tag 4 is written the next cycle with `sq_ready`=1.
- **Duplicate return:** return tag 5 twice → the first is written; the second sets `err_dup`=1, no write occurs, and `free_cnt` is unchanged.
- **Reset mid-run:** assert reset with `free_cnt`=10 → the next cycle shows `S_INIT`, `init_cnt`=0, the map cleared and `err_*`=0.
